keypad_scanner: RTL

Input-side counterpart of the seven-segment scan driver. It scans a 4x4 active-low key matrix on the 1 kHz clk_scan and debounces each press. For every accepted key it emits a one-cycle key_valid pulse with a 4-bit key_code, which the calculator control FSM turns into digits, operators and commands. Row drive and column sampling share the same scan clock domain as the display driver.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_scanner_col_sync.sv | 36 +++
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_t     : scanner FSM encoding (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   - KEY_W       : width of a key code ({row[1:0], col[1:0]})
//   - ROW_RESET   : row drive after reset (row 0 low)
//   - KEY_*       : calculator meaning of each key code
//   - row_drive() : active-low one-hot row pattern for a row index
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int          KEY_W     = 4;
  localparam logic [3:0]  ROW_RESET = 4'b1110;

  // Calculator key map: codes 0..9 are the digits themselves.
  localparam logic [KEY_W-1:0] KEY_0        = 4'd0;
  localparam logic [KEY_W-1:0] KEY_9        = 4'd9;
  localparam logic [KEY_W-1:0] KEY_OP_CYCLE = 4'd10;
  localparam logic [KEY_W-1:0] KEY_SIGN     = 4'd11;
  localparam logic [KEY_W-1:0] KEY_DP       = 4'd12;
  localparam logic [KEY_W-1:0] KEY_NEXT     = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQUALS   = 4'd14;
  localparam logic [KEY_W-1:0] KEY_CLEAR    = 4'd15;

  // Rotating the reset pattern keeps exactly one row low for every index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [7:0] dbl;
    dbl = {ROW_RESET, ROW_RESET} << idx;
    return dbl[7:4];
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// -----------------------------------------------------------------------------
// col_sync
// Two-flop synchronizer bringing the asynchronous keypad columns into the
// clk_scan domain. Resets to all-high (no key) so the scanner never sees a
// phantom press while coming out of reset.
// Ports:
//   clk_scan : scan clock
//   rst      : asynchronous active-high reset
//   col_in   : raw active-low columns
//   col_s    : synchronized columns, 2 cycles of latency
// -----------------------------------------------------------------------------
module col_sync (
  input  logic       clk_scan,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] col_s
);

  logic [3:0] sync_p0;
  logic [3:0] sync_p1;

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      sync_p0 <= 4'b1111;
      sync_p1 <= 4'b1111;
    end else begin
      // stage 0: metastability catch
      sync_p0 <= col_in;
      // stage 1: settled sample
      sync_p1 <= sync_p0;
    end
  end

  assign col_s = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low key matrix on the 1 kHz scan clock, debounces press
// and release, and reports each accepted key as a one-cycle key_valid pulse.
//
// Optional build macro: KEYPAD_AUTOREPEAT_EN
//   defined   -> held keys re-issue key_valid after REPEAT_DELAY ticks, then
//                every REPEAT_RATE ticks
//   undefined -> exactly one key_valid per accepted press
//
// Ports:
//   clk_scan  : scan clock, rising edge
//   rst       : asynchronous active-high reset
//   col_in    : matrix columns, active-low, asynchronous
//   row_out   : matrix row drive, active-low, exactly one bit low
//   key_valid : one-cycle pulse, key_code valid
//   key_code  : {row[1:0], col[1:0]}, held until the next accepted key
//   key_held  : high from accepted press until accepted release
//   multi_err : one-cycle pulse, several columns low in the sampled row
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic             clk_scan,
  input  logic             rst,
  input  logic [3:0]       col_in,
  output logic [3:0]       row_out,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic             multi_err
);

  // Repeat reload subtracts RATE from DELAY, so RATE may not exceed DELAY,
  // and DELAY has to fit the 10-bit repeat counter.
  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 255) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_TICKS must be 2..255");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY > 1023) begin : g_bad_repeat
    $error("keypad_scanner: need 1 <= REPEAT_RATE <= REPEAT_DELAY <= 1023");
  end

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_TICKS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [3:0]       col_s;
  state_t           state, state_n;
  logic [1:0]       dwell, dwell_n;
  logic [1:0]       row_ptr, row_ptr_n;
  logic [1:0]       row_idx, row_idx_n;
  logic [1:0]       col_idx, col_idx_n;
  logic [7:0]       deb_cnt, deb_n;
  logic [7:0]       deb_inc;
  logic             deb_done;
  logic             col_low;
  logic [2:0]       n_low;
  logic [1:0]       low_pos;
  logic             key_valid_n;
  logic [KEY_W-1:0] key_code_n;
  logic             key_held_n;
  logic             multi_err_n;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [9:0] REP_FIRE   = 10'(REPEAT_DELAY);
  localparam logic [9:0] REP_RELOAD = 10'(REPEAT_DELAY - REPEAT_RATE);
  logic [9:0] rep_cnt, rep_n;
  logic [9:0] rep_inc;
  assign rep_inc = rep_cnt + 10'd1;
`endif

  col_sync u_col_sync (
    .clk_scan (clk_scan),
    .rst      (rst),
    .col_in   (col_in),
    .col_s    (col_s)
  );

  assign row_out  = row_drive(row_ptr);
  assign col_low  = ~col_s[col_idx];
  assign deb_inc  = sat_inc(deb_cnt);
  // deb_cnt counts samples after the first one, so reaching DEB_LAST means
  // DEBOUNCE_TICKS consecutive matching samples.
  assign deb_done = (deb_inc == DEB_LAST);

  always_comb begin
    n_low   = {2'b00, ~col_s[0]} + {2'b00, ~col_s[1]}
            + {2'b00, ~col_s[2]} + {2'b00, ~col_s[3]};
    low_pos = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) low_pos = 2'(i);
    end
  end

  always_comb begin
    state_n     = state;
    dwell_n     = dwell;
    row_ptr_n   = row_ptr;
    row_idx_n   = row_idx;
    col_idx_n   = col_idx;
    deb_n       = deb_cnt;
    key_valid_n = 1'b0;
    key_code_n  = key_code;
    key_held_n  = key_held;
    multi_err_n = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n       = rep_cnt;
`endif
    case (state)
      SCAN: begin
        dwell_n = dwell + 2'd1;
        // Columns are only trusted on the last dwell cycle, once the row
        // drive has propagated through the synchronizer.
        if (dwell == 2'd3) begin
          if (n_low == 3'd1) begin
            row_idx_n = row_ptr;
            col_idx_n = low_pos;
            deb_n     = 8'd0;
            dwell_n   = 2'd0;
            state_n   = DEBOUNCE;
          end else begin
            multi_err_n = (n_low != 3'd0);
            row_ptr_n   = row_ptr + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_low) begin
          deb_n = deb_inc;
          if (deb_done) begin
            key_valid_n = 1'b1;
            key_code_n  = {row_idx, col_idx};
            key_held_n  = 1'b1;
            state_n     = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n       = 10'd0;
`endif
          end
        end else begin
          row_ptr_n = row_idx + 2'd1;
          dwell_n   = 2'd0;
          state_n   = SCAN;
        end
      end
      PRESSED: begin
        if (!col_low) begin
          deb_n   = 8'd0;
          state_n = RELEASE;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n = rep_inc;
          // Reloading to DELAY-RATE reuses the same compare for the
          // first repeat and all later ones.
          if (rep_inc == REP_FIRE) begin
            key_valid_n = 1'b1;
            rep_n       = REP_RELOAD;
          end
`endif
        end
      end
      RELEASE: begin
        if (col_low) begin
          state_n = PRESSED;
        end else begin
          deb_n = deb_inc;
          if (deb_done) begin
            key_held_n = 1'b0;
            row_ptr_n  = row_idx + 2'd1;
            dwell_n    = 2'd0;
            state_n    = SCAN;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      dwell     <= 2'd0;
      row_ptr   <= 2'd0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      deb_cnt   <= 8'd0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      dwell     <= dwell_n;
      row_ptr   <= row_ptr_n;
      row_idx   <= row_idx_n;
      col_idx   <= col_idx_n;
      deb_cnt   <= deb_n;
      key_valid <= key_valid_n;
      key_code  <= key_code_n;
      key_held  <= key_held_n;
      multi_err <= multi_err_n;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      rep_cnt <= 10'd0;
    end else begin
      rep_cnt <= rep_n;
    end
  end
`endif

endmodule
